// File: rtl/hq_mmio_csr_responder.sv
// MMIO CSR responder for the HQ FIFO AFU: decodes c0 MMIO reads/writes, returns c2 read completions.
// Reads complete exactly 2 cycles after the request with no stalls; writes land the following cycle.
module hq_mmio_csr_responder #(
    parameter logic [63:0] AFU_DFH      = 64'h1000_0000_0000_1000,
    parameter logic [63:0] AFU_ID_L     = 64'h0,
    parameter logic [63:0] AFU_ID_H     = 64'h0,
    parameter int unsigned RESET_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        rx_rd_valid,
    input  logic        rx_wr_valid,
    input  logic [8:0]  rx_tid,
    input  logic [15:0] rx_addr,
    input  logic [1:0]  rx_len,
    input  logic [63:0] rx_wdata,
    output logic        tx_c2_valid,
    output logic [8:0]  tx_c2_tid,
    output logic [63:0] tx_c2_data,
    output logic [63:0] ring_base,
    output logic [31:0] ring_size,
    output logic        ctl_enable,
    output logic        ctl_reset_pulse,
    input  logic [63:0] stat_msg_count
);

    localparam int unsigned      CNT_W    = $clog2(RESET_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RESET_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Register index = byte offset / 8 = rx_addr[15:1]
    localparam logic [14:0] IDX_DFH       = 15'd0;
    localparam logic [14:0] IDX_ID_L      = 15'd1;
    localparam logic [14:0] IDX_ID_H      = 15'd2;
    localparam logic [14:0] IDX_SCRATCH   = 15'd5;
    localparam logic [14:0] IDX_RING_BASE = 15'd6;
    localparam logic [14:0] IDX_RING_SIZE = 15'd7;
    localparam logic [14:0] IDX_CTRL      = 15'd8;
    localparam logic [14:0] IDX_STATUS    = 15'd9;
    localparam logic [14:0] IDX_ERR       = 15'd10;

    logic             s1_vld_q, s1_vld_d;
    logic [8:0]       s1_tid_q, s1_tid_d;
    logic [15:0]      s1_addr_q, s1_addr_d;
    logic [1:0]       s1_len_q, s1_len_d;
    logic             c2_vld_q, c2_vld_d;
    logic [8:0]       c2_tid_q, c2_tid_d;
    logic [63:0]      c2_dat_q, c2_dat_d;
    logic [63:0]      scratch_q, scratch_d;
    logic [63:0]      ring_base_q, ring_base_d;
    logic [31:0]      ring_size_q, ring_size_d;
    logic             enable_q, enable_d;
    logic [CNT_W-1:0] rst_cnt_q, rst_cnt_d;
    logic [2:0]       err_q, err_d;

    logic [14:0] wr_idx;
    logic        wr_bad_len, wr_unal, wr_lo_en, wr_hi_en;
    logic [31:0] wr_lo, wr_hi;
    logic [14:0] s1_idx;
    logic        s1_long, s1_bad_len, s1_unal;
    logic [63:0] rd_reg, rd_dat;
    logic [2:0]  err_set, err_clr;

    assign wr_idx     = rx_addr[15:1];
    assign wr_bad_len = rx_len[1];
    assign wr_unal    = (rx_len == 2'd1) && rx_addr[0];
    assign wr_lo_en   = (rx_len == 2'd1) || !rx_addr[0];
    assign wr_hi_en   = (rx_len == 2'd1) || rx_addr[0];
    // A 4B write carries its data in the low lane regardless of which half it targets
    assign wr_lo      = rx_wdata[31:0];
    assign wr_hi      = (rx_len == 2'd1) ? rx_wdata[63:32] : rx_wdata[31:0];

    assign s1_idx     = s1_addr_q[15:1];
    assign s1_long    = (s1_len_q == 2'd1);
    assign s1_bad_len = s1_len_q[1];
    assign s1_unal    = s1_long && s1_addr_q[0];

    always_comb begin
        s1_vld_d    = rx_rd_valid;
        s1_tid_d    = rx_tid;
        s1_addr_d   = rx_addr;
        s1_len_d    = rx_len;
        scratch_d   = scratch_q;
        ring_base_d = ring_base_q;
        ring_size_d = ring_size_q;
        enable_d    = enable_q;
        rst_cnt_d   = (rst_cnt_q != '0) ? rst_cnt_q - CNT_ONE : '0;
        err_set     = '0;
        err_clr     = '0;
        rd_reg      = '0;
        rd_dat      = '0;

        if (rx_wr_valid) begin
            if (wr_bad_len) begin
                err_set[0] = 1'b1;
            end else if (wr_unal) begin
                err_set[1] = 1'b1;
            end else begin
                case (wr_idx)
                    IDX_SCRATCH: begin
                        if (wr_lo_en) scratch_d[31:0]  = wr_lo;
                        if (wr_hi_en) scratch_d[63:32] = wr_hi;
                    end
                    IDX_RING_BASE: begin
                        if (wr_lo_en) ring_base_d[31:0]  = wr_lo;
                        if (wr_hi_en) ring_base_d[63:32] = wr_hi;
                        ring_base_d[5:0] = 6'h0;
                    end
                    IDX_RING_SIZE: begin
                        if (wr_lo_en) ring_size_d = wr_lo;
                    end
                    IDX_CTRL: begin
                        if (wr_lo_en) begin
                            enable_d = wr_lo[0];
                            // Soft reset wins over the enable bit and restarts the pulse
                            if (wr_lo[1]) begin
                                enable_d  = 1'b0;
                                rst_cnt_d = CNT_LOAD;
                            end
                        end
                    end
                    IDX_ERR: begin
                        if (wr_lo_en) err_clr = wr_lo[2:0];
                    end
                    default: begin
                        if (wr_idx > IDX_ERR) err_set[2] = 1'b1;
                    end
                endcase
            end
        end

        case (s1_idx)
            IDX_DFH:       rd_reg = AFU_DFH;
            IDX_ID_L:      rd_reg = AFU_ID_L;
            IDX_ID_H:      rd_reg = AFU_ID_H;
            IDX_SCRATCH:   rd_reg = scratch_q;
            IDX_RING_BASE: rd_reg = ring_base_q;
            IDX_RING_SIZE: rd_reg = {32'h0, ring_size_q};
            IDX_CTRL:      rd_reg = {63'h0, enable_q};
            IDX_STATUS:    rd_reg = stat_msg_count;
            IDX_ERR:       rd_reg = {61'h0, err_q};
            default:       rd_reg = '0;
        endcase

        if (s1_vld_q) begin
            if (s1_bad_len) begin
                err_set[0] = 1'b1;
            end else if (s1_unal) begin
                err_set[1] = 1'b1;
            end else if (s1_idx > IDX_ERR) begin
                err_set[2] = 1'b1;
            end else if (s1_long) begin
                rd_dat = rd_reg;
            end else begin
                rd_dat = {32'h0, s1_addr_q[0] ? rd_reg[63:32] : rd_reg[31:0]};
            end
        end

        // New errors take priority over a simultaneous W1C of the same bit
        err_d    = (err_q & ~err_clr) | err_set;
        c2_vld_d = s1_vld_q;
        c2_tid_d = s1_tid_q;
        c2_dat_d = rd_dat;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_vld_q    <= 1'b0;
            s1_tid_q    <= '0;
            s1_addr_q   <= '0;
            s1_len_q    <= '0;
            c2_vld_q    <= 1'b0;
            c2_tid_q    <= '0;
            c2_dat_q    <= '0;
            scratch_q   <= '0;
            ring_base_q <= '0;
            ring_size_q <= '0;
            enable_q    <= 1'b0;
            rst_cnt_q   <= '0;
            err_q       <= '0;
        end else begin
            s1_vld_q    <= s1_vld_d;
            s1_tid_q    <= s1_tid_d;
            s1_addr_q   <= s1_addr_d;
            s1_len_q    <= s1_len_d;
            c2_vld_q    <= c2_vld_d;
            c2_tid_q    <= c2_tid_d;
            c2_dat_q    <= c2_dat_d;
            scratch_q   <= scratch_d;
            ring_base_q <= ring_base_d;
            ring_size_q <= ring_size_d;
            enable_q    <= enable_d;
            rst_cnt_q   <= rst_cnt_d;
            err_q       <= err_d;
        end
    end

    assign tx_c2_valid     = c2_vld_q;
    assign tx_c2_tid       = c2_tid_q;
    assign tx_c2_data      = c2_dat_q;
    assign ring_base       = ring_base_q;
    assign ring_size       = ring_size_q;
    assign ctl_enable      = enable_q;
    assign ctl_reset_pulse = (rst_cnt_q != '0);

endmodule

// File: tb/tb_hq_mmio_csr_responder.sv
// Bench for hq_mmio_csr_responder: scoreboard of expected read completions plus direct output checks.
module tb_hq_mmio_csr_responder;

    localparam logic [63:0] DFH   = 64'h1000_0000_0000_1000;
    localparam logic [63:0] STAT0 = 64'h0000_0042_0000_0007;
    localparam logic [63:0] SCR   = 64'h0000_CAFE_0123_4567;

    logic        clk, reset_n, rx_rd_valid, rx_wr_valid;
    logic [8:0]  rx_tid;
    logic [15:0] rx_addr;
    logic [1:0]  rx_len;
    logic [63:0] rx_wdata;
    logic        tx_c2_valid;
    logic [8:0]  tx_c2_tid;
    logic [63:0] tx_c2_data;
    logic [63:0] ring_base;
    logic [31:0] ring_size;
    logic        ctl_enable, ctl_reset_pulse;
    logic [63:0] stat_msg_count;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        logic [8:0]  tid;
        logic [63:0] dat;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    hq_mmio_csr_responder dut (
        .clk(clk), .reset_n(reset_n),
        .rx_rd_valid(rx_rd_valid), .rx_wr_valid(rx_wr_valid),
        .rx_tid(rx_tid), .rx_addr(rx_addr), .rx_len(rx_len), .rx_wdata(rx_wdata),
        .tx_c2_valid(tx_c2_valid), .tx_c2_tid(tx_c2_tid), .tx_c2_data(tx_c2_data),
        .ring_base(ring_base), .ring_size(ring_size),
        .ctl_enable(ctl_enable), .ctl_reset_pulse(ctl_reset_pulse),
        .stat_msg_count(stat_msg_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Completion monitor: every c2 beat must match the oldest outstanding read
    always @(negedge clk) begin
        exp_t e;
        if (tx_c2_valid) begin
            if (sb.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_completion tid=%h data=%h required=none", tx_c2_tid, tx_c2_data);
            end else begin
                e = sb.pop_front();
                checks += 3;
                if (tx_c2_tid !== e.tid) begin
                    failures++;
                    $display("FAIL c2_tid got=%h required=%h", tx_c2_tid, e.tid);
                end
                if (tx_c2_data !== e.dat) begin
                    failures++;
                    $display("FAIL c2_data tid=%h got=%h required=%h", e.tid, tx_c2_data, e.dat);
                end
                if (cyc != e.cyc + 2) begin
                    failures++;
                    $display("FAIL c2_latency tid=%h got=%0d required=2", e.tid, cyc - e.cyc);
                end
            end
        end
    end

    task automatic rd(input logic [15:0] a, input logic [1:0] l, input logic [8:0] t, input logic [63:0] e);
        exp_t x;
        rx_rd_valid = 1'b1; rx_addr = a; rx_len = l; rx_tid = t;
        x.tid = t; x.dat = e; x.cyc = cyc;
        sb.push_back(x);
        @(negedge clk);
        rx_rd_valid = 1'b0;
    endtask

    task automatic wr(input logic [15:0] a, input logic [1:0] l, input logic [63:0] d);
        rx_wr_valid = 1'b1; rx_addr = a; rx_len = l; rx_wdata = d;
        @(negedge clk);
        rx_wr_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL %s_drain pending=%0d required=0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks += 4;
        if (tx_c2_valid !== 1'b0 || tx_c2_tid !== 9'h0 || tx_c2_data !== 64'h0) begin
            failures++;
            $display("FAIL reset_c2 got=%b/%h/%h required=0/0/0", tx_c2_valid, tx_c2_tid, tx_c2_data);
        end
        if (ring_base !== 64'h0) begin failures++; $display("FAIL reset_ring_base got=%h required=0", ring_base); end
        if (ring_size !== 32'h0) begin failures++; $display("FAIL reset_ring_size got=%h required=0", ring_size); end
        if (ctl_enable !== 1'b0 || ctl_reset_pulse !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctl got=%b%b required=00", ctl_enable, ctl_reset_pulse);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_dfh;
        rd(16'h000, 2'd1, 9'h1A5, DFH);
        rd(16'h002, 2'd1, 9'h001, 64'h0);
        rd(16'h004, 2'd1, 9'h002, 64'h0);
        drain("dfh");
    endtask

    task automatic test_scratch;
        wr(16'h00A, 2'd1, 64'hDEAD_BEEF_0123_4567);
        rd(16'h00A, 2'd0, 9'h010, 64'h0123_4567);
        rd(16'h00B, 2'd0, 9'h011, 64'hDEAD_BEEF);
        wr(16'h00B, 2'd0, 64'h0000_0000_0000_CAFE);
        wr(16'h00A, 2'd0, 64'h1111_1111_0123_4567);
        rd(16'h00A, 2'd1, 9'h012, SCR);
        drain("scratch");
    endtask

    task automatic test_ring;
        wr(16'h00C, 2'd1, 64'h1234_567F);
        checks++;
        if (ring_base !== 64'h1234_5640) begin failures++; $display("FAIL ring_base got=%h required=%h", ring_base, 64'h1234_5640); end
        rd(16'h00C, 2'd1, 9'h020, 64'h1234_5640);
        wr(16'h00E, 2'd0, 64'h100);
        checks++;
        if (ring_size !== 32'h100) begin failures++; $display("FAIL ring_size got=%h required=100", ring_size); end
        rd(16'h00E, 2'd1, 9'h021, 64'h100);
        drain("ring");
    endtask

    task automatic pulse_run(input bit rewrite, input int exp_len);
        int n = 0;
        int last = 0;
        int en_hi = 0;
        rx_wr_valid = 1'b1; rx_addr = 16'h010; rx_len = 2'd1; rx_wdata = 64'h3;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            rx_wr_valid = 1'b0;
            if (ctl_reset_pulse) begin n++; last = i; end
            if (ctl_enable) en_hi++;
            if (rewrite && i == 8) begin
                rx_wr_valid = 1'b1; rx_addr = 16'h010; rx_len = 2'd1; rx_wdata = 64'h3;
            end
        end
        checks += 3;
        if (n != exp_len) begin failures++; $display("FAIL pulse_len got=%0d required=%0d", n, exp_len); end
        if (last != exp_len) begin failures++; $display("FAIL pulse_last got=%0d required=%0d", last, exp_len); end
        if (en_hi != 0) begin failures++; $display("FAIL pulse_enable got=%0d required=0", en_hi); end
    endtask

    task automatic test_ctrl;
        wr(16'h010, 2'd1, 64'h1);
        checks++;
        if (ctl_enable !== 1'b1) begin failures++; $display("FAIL ctl_enable got=%b required=1", ctl_enable); end
        pulse_run(1'b0, 16);
        pulse_run(1'b1, 24);
        rd(16'h010, 2'd1, 9'h030, 64'h0);
        drain("ctrl");
    endtask

    task automatic test_back_to_back;
        logic [15:0] ta[20] = '{16'h000, 16'h002, 16'h004, 16'h006, 16'h008, 16'h00A, 16'h00C,
                                16'h00E, 16'h010, 16'h012, 16'h016, 16'h000, 16'h001, 16'h00A,
                                16'h00B, 16'h00D, 16'h012, 16'h013, 16'h00F, 16'hFFFE};
        logic [1:0]  tl[20] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1,
                                2'd1, 2'd0, 2'd0, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1};
        logic [63:0] te[20] = '{DFH, 64'h0, 64'h0, 64'h0, 64'h0, SCR, 64'h1234_5640,
                                64'h100, 64'h0, STAT0, 64'h0, 64'h1000, 64'h1000_0000, 64'h0,
                                64'h0000_CAFE, 64'h0, 64'h7, 64'h42, 64'h0, 64'h0};
        for (int i = 0; i < 20; i++) rd(ta[i], tl[i], 9'(9'h040 + i), te[i]);
        rd(16'h014, 2'd1, 9'h060, 64'h5);
        wr(16'h014, 2'd1, 64'h5);
        rd(16'h014, 2'd1, 9'h061, 64'h0);
        drain("b2b");
    endtask

    task automatic test_errors;
        rd(16'h001, 2'd1, 9'h070, 64'h0);
        rd(16'h014, 2'd1, 9'h071, 64'h2);
        wr(16'h00B, 2'd1, 64'hFFFF_FFFF_FFFF_FFFF);
        wr(16'h00A, 2'd2, 64'hFFFF_FFFF_FFFF_FFFF);
        wr(16'h000, 2'd1, 64'hFFFF_FFFF_FFFF_FFFF);
        wr(16'h012, 2'd1, 64'hFFFF_FFFF_FFFF_FFFF);
        rd(16'h00A, 2'd1, 9'h072, SCR);
        rd(16'h000, 2'd1, 9'h073, DFH);
        rd(16'h014, 2'd1, 9'h074, 64'h3);
        wr(16'h014, 2'd0, 64'h3);
        rd(16'h014, 2'd1, 9'h075, 64'h0);
        // Unmapped read decodes in the same cycle the W1C of bit2 lands
        rd(16'h016, 2'd1, 9'h076, 64'h0);
        wr(16'h014, 2'd1, 64'h4);
        rd(16'h014, 2'd1, 9'h077, 64'h4);
        wr(16'h014, 2'd1, 64'h4);
        rd(16'h014, 2'd1, 9'h078, 64'h0);
        drain("errors");
    endtask

    task automatic test_status;
        stat_msg_count = 64'hAAAA_0000_0000_0001;
        rd(16'h012, 2'd1, 9'h080, 64'hBBBB_0000_0000_0002);
        stat_msg_count = 64'hBBBB_0000_0000_0002;
        @(negedge clk);
        stat_msg_count = STAT0;
        drain("status");
    endtask

    task automatic test_collide;
        exp_t x;
        rx_rd_valid = 1'b1; rx_wr_valid = 1'b1;
        rx_addr = 16'h00A; rx_len = 2'd1; rx_tid = 9'h090; rx_wdata = 64'h5555_AAAA_0F0F_0F0F;
        x.tid = 9'h090; x.dat = 64'h5555_AAAA_0F0F_0F0F; x.cyc = cyc;
        sb.push_back(x);
        @(negedge clk);
        rx_rd_valid = 1'b0; rx_wr_valid = 1'b0;
        rd(16'h00A, 2'd1, 9'h091, 64'h5555_AAAA_0F0F_0F0F);
        drain("collide");
    endtask

    task automatic test_reset_inflight;
        wr(16'h010, 2'd1, 64'h1);
        wr(16'h016, 2'd1, 64'h1);
        rx_rd_valid = 1'b1; rx_addr = 16'h000; rx_len = 2'd1; rx_tid = 9'h0A0;
        @(negedge clk);
        rx_tid = 9'h0A1; rx_addr = 16'h00A;
        reset_n = 1'b0;
        #1 rx_rd_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        checks += 3;
        if (ring_base !== 64'h0 || ring_size !== 32'h0) begin
            failures++;
            $display("FAIL inflight_ring got=%h/%h required=0/0", ring_base, ring_size);
        end
        if (ctl_enable !== 1'b0 || ctl_reset_pulse !== 1'b0) begin
            failures++;
            $display("FAIL inflight_ctl got=%b%b required=00", ctl_enable, ctl_reset_pulse);
        end
        if (tx_c2_valid !== 1'b0) begin failures++; $display("FAIL inflight_c2 got=%b required=0", tx_c2_valid); end
        rd(16'h00A, 2'd1, 9'h0B0, 64'h0);
        rd(16'h014, 2'd1, 9'h0B1, 64'h0);
        rd(16'h010, 2'd1, 9'h0B2, 64'h0);
        rd(16'h00C, 2'd1, 9'h0B3, 64'h0);
        drain("inflight");
    endtask

    initial begin
        rx_rd_valid = 1'b0; rx_wr_valid = 1'b0; rx_tid = '0; rx_addr = '0;
        rx_len = '0; rx_wdata = '0; stat_msg_count = STAT0;
        test_reset();
        test_dfh();
        test_scratch();
        test_ring();
        test_ctrl();
        test_back_to_back();
        test_errors();
        test_status();
        test_collide();
        test_reset_inflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time_limit_expired required=finish");
        $fatal(1, "watchdog");
    end

endmodule
